ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
Shares one ula32 instance between two requesters (e.g. the main datapath and an address/branch unit). Each requester uses a valid/ready request channel and a valid/ready response channel. Grants are issued round-robin. The block drives the ALU operands and control from registers, captures ULAResult/Zero, and returns them to the granted requester. Opcodes outside the ALU's defined set are rejected with an error response.

Parameters:
WIDTH, 32, operand/result width; must match the ALU width.
OPW, 4, ALU control code width.
CNTW, 16, width of the per-requester saturating grant counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OPW  requester 0 ALU control code
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
rsp0_valid  out  1  response for requester 0 available
rsp0_ready  in  1  requester 0 consumes response
rsp0_result  out  WIDTH  result for requester 0
rsp0_zero  out  1  Zero flag for requester 0
rsp0_err  out  1  requester 0 sent an illegal opcode
req1_*/rsp1_*  same set as above, for requester 1
ula_control  out  OPW  to ALU ULAControl
ula_a  out  WIDTH  to ALU scrA
ula_b  out  WIDTH  to ALU scrB
ula_result  in  WIDTH  from ALU ULAResult
ula_zero  in  1  from ALU Zero
grant_cnt0  out  CNTW  accepted requests from requester 0, saturating
grant_cnt1  out  CNTW  accepted requests from requester 1, saturating

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - All outputs go to 0: rsp*, ula_*, grant_cnt*.
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - reqN_ready is combinational: high only when state==IDLE, reqN_valid==1, and N wins arbitration.
  - Arbitration:
    - If only one requester is valid, it wins.
    - If both are valid, the requester that is not last_grant wins.
  - At most one ready is high per cycle.
  - On a handshake:
    - register ula_control=op, ula_a=a, ula_b=b;
    - owner=N;
    - err_pend = (op > 4'b1000);
    - grant_cntN++ (holds at all-ones);
    - go to EXEC.
  - If there is no valid, stay in IDLE.
- EXEC (exactly 1 cycle): the ALU inputs are stable from the registers; capture the response at the end of the cycle.
  - Legal op: rsp_result=ula_result, rsp_zero=ula_zero, rsp_err=0.
  - Illegal op (9..15): rsp_result=0, rsp_zero=1, rsp_err=1; ula_result is ignored.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp_valid stays 0.
  - result, zero and err are held stable while valid is high.
  - When rsp<owner>_ready=1:
    - deassert valid next cycle;
    - last_grant=owner;
    - go to IDLE.
  - Both req_ready signals are 0 in EXEC and RESP.
- Latency: handshake cycle T → rsp_valid at T+2. Minimum 3 cycles per operation. Backpressure on the response stalls the arbiter.
- ula_control/ula_a/ula_b hold their last values after an operation, so the ALU output does not toggle when idle.
- Requesters hold op/a/b stable while valid is high and ready is low. Dropping valid before ready is tolerated; no grant is issued.
- Response outputs for the non-owner port read 0.
- Reset mid-operation (EXEC or RESP): the transaction is discarded and no response is produced; the counters clear.
- A counter at all-ones stays at all-ones on further grants.
- Arithmetic is entirely in the ALU; this block does no computation on the operands.

Test Plan:
- Single add: req0 op=0000, a=5, b=7 → req0_ready the same cycle; ula_a=5, ula_b=7 next cycle; rsp0_valid 2 cycles after the handshake with result=12, zero=0, err=0; grant_cnt0=1.
- Simultaneous requests:
  - Stimulus: after reset, both valid; req0 SUB a=9, b=9; req1 OR a=0xF0, b=0x0F.
  - Required: req0 served first (result=0, zero=1); req1 served next (result=0xFF).
  - Then repeat with both valid again: req0 served first again, because last_grant=1.
- Sustained contention: both valid continuously for 6 operations → grants alternate 0,1,0,1,0,1; grant_cnt0=grant_cnt1=3; one operation completes every 3 cycles with rsp_ready tied high.
- Backpressure: req1 op=1000, a=0x80000000, b=4; hold rsp1_ready=0 for 5 cycles → rsp1_valid stays high with result=0xF8000000 stable; req0_valid is high but req0_ready stays 0 until one cycle after rsp1_ready rises.
- Illegal opcode: req0 op=1011 → rsp0_err=1, result=0, zero=1; the next legal request completes normally with err=0.
- Reset mid-operation: assert reset during RESP → rsp*_valid=0 immediately (asynchronously); no response after reset release; grant_cnt*=0; first tie goes to req0.

Source files
------------

// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one ula32 between two valid/ready requesters.
// Requests are granted round-robin. Operands and control are presented to the ALU from
// registers. The result and Zero flag are captured after one EXEC cycle and returned on
// the granted requester's response channel. Opcodes above 4'b1000 get an error response.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; arbitration and handshake happen here
// EXEC  | ALU inputs stable from registers; response captured at cycle end
// RESP  | response held on the owner's channel until it is consumed
module ula_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,

  output logic [OPW-1:0]   ula_control,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  input  logic [WIDTH-1:0] ula_result,
  input  logic             ula_zero,

  output logic [CNTW-1:0]  grant_cnt0,
  output logic [CNTW-1:0]  grant_cnt1
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  // Highest opcode the ALU defines; anything above it is rejected.
  localparam logic [OPW-1:0]  OP_MAX  = OPW'(8);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic             err_pend_q, err_pend_d;
  logic [OPW-1:0]   ula_control_q, ula_control_d;
  logic [WIDTH-1:0] ula_a_q, ula_a_d;
  logic [WIDTH-1:0] ula_b_q, ula_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNTW-1:0]  grant_cnt0_q, grant_cnt0_d;
  logic [CNTW-1:0]  grant_cnt1_q, grant_cnt1_d;

  logic             win0, win1;
  logic             owner_rsp_ready;

  // Round-robin arbitration: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    win0 = req0_valid & (~req1_valid | last_grant_q);
    win1 = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = (state_q == IDLE) & win0;
    req1_ready = (state_q == IDLE) & win1;
  end

  // Next-state and datapath register updates for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    err_pend_d    = err_pend_q;
    ula_control_d = ula_control_q;
    ula_a_d       = ula_a_q;
    ula_b_d       = ula_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_err_d     = rsp_err_q;
    grant_cnt0_d  = grant_cnt0_q;
    grant_cnt1_d  = grant_cnt1_q;
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          ula_control_d = req0_op;
          ula_a_d       = req0_a;
          ula_b_d       = req0_b;
          owner_d       = 1'b0;
          err_pend_d    = (req0_op > OP_MAX);
          if (grant_cnt0_q != CNT_MAX) grant_cnt0_d = grant_cnt0_q + CNTW'(1);
          state_d       = EXEC;
        end else if (req1_ready) begin
          ula_control_d = req1_op;
          ula_a_d       = req1_a;
          ula_b_d       = req1_b;
          owner_d       = 1'b1;
          err_pend_d    = (req1_op > OP_MAX);
          if (grant_cnt1_q != CNT_MAX) grant_cnt1_d = grant_cnt1_q + CNTW'(1);
          state_d       = EXEC;
        end
      end
      EXEC: begin
        // An illegal opcode never reaches the requester; the ALU output is ignored.
        if (err_pend_q) begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b1;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = ula_result;
          rsp_zero_d   = ula_zero;
          rsp_err_d    = 1'b0;
        end
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      err_pend_q    <= 1'b0;
      ula_control_q <= '0;
      ula_a_q       <= '0;
      ula_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      grant_cnt0_q  <= '0;
      grant_cnt1_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      err_pend_q    <= err_pend_d;
      ula_control_q <= ula_control_d;
      ula_a_q       <= ula_a_d;
      ula_b_q       <= ula_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_err_q     <= rsp_err_d;
      grant_cnt0_q  <= grant_cnt0_d;
      grant_cnt1_q  <= grant_cnt1_d;
    end
  end

  // Steer the single response register to the owning port; the other port reads 0.
  always_comb begin
    rsp0_valid  = rsp_valid_q & ~owner_q;
    rsp0_result = owner_q ? '0 : rsp_result_q;
    rsp0_zero   = ~owner_q & rsp_zero_q;
    rsp0_err    = ~owner_q & rsp_err_q;
    rsp1_valid  = rsp_valid_q & owner_q;
    rsp1_result = owner_q ? rsp_result_q : '0;
    rsp1_zero   = owner_q & rsp_zero_q;
    rsp1_err    = owner_q & rsp_err_q;
    ula_control = ula_control_q;
    ula_a       = ula_a_q;
    ula_b       = ula_b_q;
    grant_cnt0  = grant_cnt0_q;
    grant_cnt1  = grant_cnt1_q;
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a behavioural ula32 on the ALU side.
module tb_ula_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  ula_control;
  logic [31:0] ula_a, ula_b, ula_result;
  logic        ula_zero;
  logic [15:0] grant_cnt0, grant_cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  ula_arbiter #(.WIDTH(32), .OPW(4), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .ula_control(ula_control), .ula_a(ula_a), .ula_b(ula_b),
    .ula_result(ula_result), .ula_zero(ula_zero),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  // ula32 model: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra.
  always_comb begin
    case (ula_control)
      4'd0: ula_result = ula_a + ula_b;
      4'd1: ula_result = ula_a - ula_b;
      4'd2: ula_result = ula_a & ula_b;
      4'd3: ula_result = ula_a | ula_b;
      4'd4: ula_result = ula_a ^ ula_b;
      4'd5: ula_result = {31'd0, $signed(ula_a) < $signed(ula_b)};
      4'd6: ula_result = ula_a << ula_b[4:0];
      4'd7: ula_result = ula_a >> ula_b[4:0];
      4'd8: ula_result = $signed(ula_a) >>> ula_b[4:0];
      default: ula_result = 32'hDEAD_BEEF;
    endcase
    ula_zero = (ula_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    tick(); tick();

    // Reset state
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_ula_a", ula_a, 32'd0);
    chk("rst_ula_ctrl", {28'd0, ula_control}, 32'd0);
    chk("rst_cnt0", {16'd0, grant_cnt0}, 32'd0);
    chk("rst_cnt1", {16'd0, grant_cnt1}, 32'd0);
    reset = 1'b0;
    tick();

    // Single add
    req0_valid = 1; req0_op = 4'b0000; req0_a = 5; req0_b = 7;
    #1;
    chk("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("add_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 0;
    chk("add_ula_a", ula_a, 32'd5);
    chk("add_ula_b", ula_b, 32'd7);
    chk("add_exec_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("add_cnt0", {16'd0, grant_cnt0}, 32'd1);
    tick();
    chk("add_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_result", rsp0_result, 32'd12);
    chk("add_zero", {31'd0, rsp0_zero}, 32'd0);
    chk("add_err", {31'd0, rsp0_err}, 32'd0);
    chk("add_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    tick();
    chk("add_done_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("add_hold_ula_a", ula_a, 32'd5);

    // Simultaneous requests after reset
    pulse_reset();
    req0_valid = 1; req0_op = 4'b0001; req0_a = 9;     req0_b = 9;
    req1_valid = 1; req1_op = 4'b0011; req1_a = 32'hF0; req1_b = 32'h0F;
    #1;
    chk("sim_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("sim_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 0;
    chk("sim_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("sim_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("sim_rsp0_result", rsp0_result, 32'd0);
    chk("sim_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
    chk("sim_resp_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("sim_req1_ready2", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    tick();
    chk("sim_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("sim_rsp1_result", rsp1_result, 32'hFF);
    chk("sim_rsp0_result_nonowner", rsp0_result, 32'd0);
    tick();
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("sim2_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("sim2_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick(); tick(); tick();
    chk("sim2_cnt0", {16'd0, grant_cnt0}, 32'd2);
    chk("sim2_cnt1", {16'd0, grant_cnt1}, 32'd1);

    // Sustained contention: six operations, alternating, one every 3 cycles
    pulse_reset();
    req0_valid = 1; req0_op = 4'b0000; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_op = 4'b0000; req1_a = 2; req1_b = 2;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk("rr_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("rr_req1_ready", {31'd0, req1_ready}, 32'd0);
      end else begin
        chk("rr_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rr_req1_ready", {31'd0, req1_ready}, 32'd1);
      end
      tick(); tick();
      if (i % 2 == 0) begin
        chk("rr_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("rr_rsp0_result", rsp0_result, 32'd2);
      end else begin
        chk("rr_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("rr_rsp1_result", rsp1_result, 32'd4);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_cnt0", {16'd0, grant_cnt0}, 32'd3);
    chk("rr_cnt1", {16'd0, grant_cnt1}, 32'd3);
    tick();

    // Backpressure on requester 1 (last grant was 1, but req1 is alone)
    rsp1_ready = 0;
    req1_valid = 1; req1_op = 4'b1000; req1_a = 32'h8000_0000; req1_b = 4;
    #1;
    chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_op = 4'b0000; req0_a = 3; req0_b = 4;
    #1;
    chk("bp_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("bp_rsp1_result", rsp1_result, 32'hF800_0000);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      tick();
    end
    rsp1_ready = 1;
    #1;
    chk("bp_release_req0_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    chk("bp_done_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("bp_after_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 0;
    tick();
    chk("bp_rsp0_result", rsp0_result, 32'd7);
    tick();

    // Illegal opcode, then a legal one
    req0_valid = 1; req0_op = 4'b1011; req0_a = 5; req0_b = 5;
    #1;
    chk("ill_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 0;
    tick();
    chk("ill_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("ill_err", {31'd0, rsp0_err}, 32'd1);
    chk("ill_result", rsp0_result, 32'd0);
    chk("ill_zero", {31'd0, rsp0_zero}, 32'd1);
    tick();
    req0_valid = 1; req0_op = 4'b0000; req0_a = 1; req0_b = 2;
    tick();
    req0_valid = 0;
    tick();
    chk("leg_err", {31'd0, rsp0_err}, 32'd0);
    chk("leg_result", rsp0_result, 32'd3);
    chk("leg_zero", {31'd0, rsp0_zero}, 32'd0);
    tick();

    // Reset while in RESP
    rsp1_ready = 0;
    req1_valid = 1; req1_op = 4'b0000; req1_a = 1; req1_b = 1;
    tick();
    req1_valid = 0;
    tick();
    chk("mid_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_async_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("mid_cnt0", {16'd0, grant_cnt0}, 32'd0);
    chk("mid_cnt1", {16'd0, grant_cnt1}, 32'd0);
    tick();
    reset = 1'b0;
    rsp1_ready = 1;
    tick(); tick(); tick();
    chk("mid_no_rsp1", {31'd0, rsp1_valid}, 32'd0);
    chk("mid_no_rsp0", {31'd0, rsp0_valid}, 32'd0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("mid_tie_req0", {31'd0, req0_ready}, 32'd1);
    chk("mid_tie_req1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
